// File: rtl/count_monitor_display.sv
// count_monitor_display
// Watches a 4-bit loadable up-counter and classifies each transition.
// A transition can be a normal increment, a 15->0 wrap, a load or an
// anomalous jump. The block keeps a saturating wrap count and scans a
// two-digit seven-segment display: digit0 shows the live count and
// digit1 shows the wrap count.
module count_monitor_display #(
  parameter int unsigned REFRESH_DIV = 4,
  parameter int unsigned OVF_WIDTH   = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [3:0]           qin_i,
  input  logic                 sel_i,
  output logic [6:0]           seg_o,
  output logic [1:0]           an_o,
  output logic                 wrap_o,
  output logic                 jump_o,
  output logic [OVF_WIDTH-1:0] ovf_count_o,
  output logic                 ovf_sat_o
);

  localparam logic [15:0] REF_LAST = 16'(REFRESH_DIV - 1);

  logic [3:0]           q_prev_q;
  logic                 sel_d_q;
  logic                 valid_q;
  logic [15:0]          ref_q, ref_d;
  logic                 digit_q, digit_d;
  logic [6:0]           seg_q, seg_d;
  logic [1:0]           an_q, an_d;
  logic                 wrap_q, wrap_d;
  logic                 jump_q, jump_d;
  logic [OVF_WIDTH-1:0] ovf_count_q, ovf_count_d;
  logic                 ovf_sat_q, ovf_sat_d;
  logic [3:0]           q_inc;
  logic [3:0]           disp_nib;
  logic                 ref_last;

  // Segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Transition classification, wrap counting and display scan next-state.
  always_comb begin
    q_inc       = q_prev_q + 4'd1;
    // A load on the previous edge explains any value change, so a load
    // blocks both pulses. A 15->0 wrap equals prev+1, so it never jumps.
    wrap_d      = valid_q && !sel_d_q && (q_prev_q == 4'hF) && (qin_i == 4'h0);
    jump_d      = valid_q && !sel_d_q && (qin_i != q_inc);
    ovf_count_d = ovf_count_q;
    ovf_sat_d   = ovf_sat_q;
    if (wrap_d) begin
      if (ovf_count_q == '1) ovf_sat_d = 1'b1;
      else                   ovf_count_d = ovf_count_q + 1'b1;
    end
    ref_last = (ref_q == REF_LAST);
    ref_d    = ref_last ? 16'd0 : ref_q + 16'd1;
    digit_d  = digit_q ^ ref_last;
    // an and seg come from the same digit_q, so they always name the same digit.
    an_d     = digit_q ? 2'b10 : 2'b01;
    disp_nib = digit_q ? 4'(ovf_count_q) : qin_i;
    seg_d    = hex7(disp_nib);
  end

  // All state updates. Reset wins over any transition seen in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_prev_q    <= 4'h0;
      sel_d_q     <= 1'b0;
      valid_q     <= 1'b0;
      ref_q       <= 16'd0;
      digit_q     <= 1'b0;
      seg_q       <= 7'h00;
      an_q        <= 2'b00;
      wrap_q      <= 1'b0;
      jump_q      <= 1'b0;
      ovf_count_q <= '0;
      ovf_sat_q   <= 1'b0;
    end else begin
      q_prev_q    <= qin_i;
      sel_d_q     <= sel_i;
      valid_q     <= 1'b1;
      ref_q       <= ref_d;
      digit_q     <= digit_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      wrap_q      <= wrap_d;
      jump_q      <= jump_d;
      ovf_count_q <= ovf_count_d;
      ovf_sat_q   <= ovf_sat_d;
    end
  end

  assign seg_o       = seg_q;
  assign an_o        = an_q;
  assign wrap_o      = wrap_q;
  assign jump_o      = jump_q;
  assign ovf_count_o = ovf_count_q;
  assign ovf_sat_o   = ovf_sat_q;

endmodule

// File: tb/tb_count_monitor_display.sv
// Testbench for count_monitor_display: directed and random stimulus, with a
// behavioural reference model feeding an expected-value queue.
module tb_count_monitor_display;

  localparam int unsigned DIV = 4;

  logic       clk;
  logic       rst;
  logic [3:0] qin;
  logic       sel;
  logic [6:0] seg,  seg1;
  logic [1:0] an,   an1;
  logic       wrap, wrap1;
  logic       jump, jump1;
  logic [3:0] ovf,  ovf1;
  logic       sat,  sat1;

  count_monitor_display #(.REFRESH_DIV(DIV), .OVF_WIDTH(4)) dut (
    .clk_i(clk), .reset_i(rst), .qin_i(qin), .sel_i(sel),
    .seg_o(seg), .an_o(an), .wrap_o(wrap), .jump_o(jump),
    .ovf_count_o(ovf), .ovf_sat_o(sat)
  );

  count_monitor_display #(.REFRESH_DIV(1), .OVF_WIDTH(4)) dut1 (
    .clk_i(clk), .reset_i(rst), .qin_i(qin), .sel_i(sel),
    .seg_o(seg1), .an_o(an1), .wrap_o(wrap1), .jump_o(jump1),
    .ovf_count_o(ovf1), .ovf_sat_o(sat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // expected {seg,an,wrap,jump,ovf_count,ovf_sat} for the main DUT, an for dut1
  logic [15:0] sb  [$];
  logic [1:0]  sb1 [$];

  // reference model state
  logic [3:0]  m_prev;
  logic        m_seld, m_valid, m_sat, m_dig, m_dig1;
  logic [3:0]  m_cnt;
  int unsigned m_ref;
  logic [3:0]  cur;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  // One clock: drive inputs, predict outputs after the edge, then check.
  task automatic step(input logic [3:0] q, input logic s, input logic r, input string tag);
    logic [15:0] e, got, exp;
    logic [1:0]  e1, got1, exp1;
    logic        w, j;
    logic [1:0]  a;
    logic [6:0]  sg;
    qin = q; sel = s; rst = r;
    if (r) begin
      e = 16'h0; e1 = 2'b00;
      m_prev = 4'h0; m_seld = 1'b0; m_valid = 1'b0; m_cnt = 4'h0; m_sat = 1'b0;
      m_ref = 0; m_dig = 1'b0; m_dig1 = 1'b0;
    end else begin
      w  = m_valid && !m_seld && (m_prev == 4'hF) && (q == 4'h0);
      j  = m_valid && !m_seld && (q != 4'(m_prev + 4'd1));
      a  = m_dig ? 2'b10 : 2'b01;
      sg = seg_of(m_dig ? m_cnt : q);
      if (w) begin
        if (m_cnt == 4'hF) m_sat = 1'b1;
        else               m_cnt = m_cnt + 4'd1;
      end
      e = {sg, a, w, j, m_cnt, m_sat};
      if (m_ref == DIV - 1) begin m_ref = 0; m_dig = !m_dig; end
      else m_ref = m_ref + 1;
      e1 = m_dig1 ? 2'b10 : 2'b01;
      m_dig1 = !m_dig1;
      m_prev = q; m_seld = s; m_valid = 1'b1;
    end
    sb.push_back(e);
    sb1.push_back(e1);
    @(posedge clk);
    #1;
    got  = {seg, an, wrap, jump, ovf, sat};
    exp  = sb.pop_front();
    got1 = an1;
    exp1 = sb1.pop_front();
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed seg=%h an=%b wrap=%b jump=%b ovf=%h sat=%b expected seg=%h an=%b wrap=%b jump=%b ovf=%h sat=%b",
             tag, got[15:9], got[8:7], got[6], got[5], got[4:1], got[0],
             exp[15:9], exp[8:7], exp[6], exp[5], exp[4:1], exp[0]);
    end
    compared++;
    assert (got1 === exp1) else begin
      mismatched++;
      $error("FAIL %s_div1_an: observed %b expected %b", tag, got1, exp1);
    end
  endtask

  initial begin
    qin = 4'h0; sel = 1'b0; rst = 1'b1;
    m_prev = 4'h0; m_seld = 1'b0; m_valid = 1'b0; m_cnt = 4'h0; m_sat = 1'b0;
    m_ref = 0; m_dig = 1'b0; m_dig1 = 1'b0;

    // reset state
    step(4'h0, 1'b0, 1'b1, "reset0");
    step(4'h0, 1'b0, 1'b1, "reset1");

    // free run 0..15 then 0,1: single wrap pulse, no jumps
    for (int i = 0; i < 18; i++) step(4'(i), 1'b0, 1'b0, "freerun");

    // 17 more full wraps: ovf saturates at 15, sat sticky
    cur = 4'h2;
    for (int i = 0; i < 17 * 16; i++) begin
      step(cur, 1'b0, 1'b0, "wraps");
      cur = cur + 4'd1;
    end

    // load then hold: load silent, two hold jumps
    step(4'h0, 1'b0, 1'b1, "rst_load");
    step(4'h4, 1'b0, 1'b0, "capture");
    step(4'h5, 1'b1, 1'b0, "sel5");
    step(4'hC, 1'b0, 1'b0, "loadC");
    step(4'hC, 1'b0, 1'b0, "hold1");
    step(4'hC, 1'b0, 1'b0, "hold2");
    step(4'hD, 1'b0, 1'b0, "incD");

    // sel during 15->0 is a load, not a wrap
    step(4'hE, 1'b0, 1'b0, "preE");
    step(4'hF, 1'b1, 1'b0, "selF");
    step(4'h0, 1'b0, 1'b0, "loadwrap");
    step(4'h1, 1'b0, 1'b0, "post1");

    // display scan: ovf_count=3, qin held at A
    step(4'h0, 1'b0, 1'b1, "rst_disp");
    cur = 4'h0;
    for (int i = 0; i < 3 * 16 + 1; i++) begin
      step(cur, 1'b0, 1'b0, "to_ovf3");
      cur = cur + 4'd1;
    end
    for (int i = 0; i < 20; i++) step(4'hA, 1'b0, 1'b0, "scanA");

    // saturate, then reset while digit1 is shown
    for (int i = 0; i < 16 * 16; i++) begin
      step(cur, 1'b0, 1'b0, "to_sat");
      cur = cur + 4'd1;
    end
    for (int i = 0; i < 8 && !m_dig; i++) begin
      step(cur, 1'b0, 1'b0, "to_dig1");
      cur = cur + 4'd1;
    end
    step(4'hF, 1'b0, 1'b0, "pre_rst_F");
    step(4'h0, 1'b0, 1'b1, "rst_on_wrap");
    step(4'h7, 1'b0, 1'b0, "post_rst_capture");
    step(4'h8, 1'b0, 1'b0, "post_rst_inc");
    step(4'h3, 1'b0, 1'b0, "post_rst_jump");

    // random mix of increments, loads and jumps
    cur = 4'h3;
    for (int i = 0; i < 200; i++) begin
      logic s;
      s   = ($urandom_range(0, 5) == 0);
      cur = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : cur + 4'd1;
      step(cur, s, ($urandom_range(0, 99) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
